// File: rtl/std_divmod_pkg.sv
// Shared types for the streaming divide/modulo unit.
//   divmod_state_e  : controller states (IDLE, BUSY, HOLD)
//   divmod_result_t : quotient, remainder and divide-by-zero flag. Fields are
//                     sized for the widest legal instance; an instantiator
//                     zero-extends into it and slices its own width back out.
package std_divmod_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } divmod_state_e;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] quotient;
    logic [MAX_WIDTH-1:0] remainder;
    logic                 div_by_zero;
  } divmod_result_t;

endpackage

// File: rtl/std_divmod_core.sv
// Restoring-division datapath: one quotient bit per step.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   load             capture left/right, clear remainder and counter
//   step             perform one iteration
//   left, right      dividend / divisor operands
//   last             counter is on the final iteration
//   quotient_next    quotient after the current iteration (combinational)
//   remainder_next   remainder after the current iteration (combinational)
//   div_by_zero      latched divisor is zero
module std_divmod_core
  import std_divmod_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic             last,
  output logic [width-1:0] quotient_next,
  output logic [width-1:0] remainder_next,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(width) + 1;

  // Dividend and quotient share one register: the dividend shifts out of the
  // MSB while quotient bits shift into the freed LSB.
  logic [width-1:0] work_q;
  logic [width-1:0] divisor_q;
  logic [width-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [width:0]   rem_shift;
  logic             rem_ge;

  always_comb begin
    rem_shift      = {rem_q, work_q[width-1]};
    rem_ge         = rem_shift >= {1'b0, divisor_q};
    // After a successful subtract the result is below the divisor, so the
    // low width bits hold it exactly.
    remainder_next = rem_ge ? (rem_shift[width-1:0] - divisor_q) : rem_shift[width-1:0];
    quotient_next  = {work_q[width-2:0], rem_ge};
    last           = (cnt_q == CNT_W'(width - 1));
    div_by_zero    = (divisor_q == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      work_q    <= left;
      divisor_q <= right;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else if (step) begin
      work_q    <= quotient_next;
      rem_q     <= remainder_next;
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/std_divmod_stream.sv
// Streaming unsigned divide/modulo with ready/valid on both sides and a
// single-entry result hold register.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid, in_ready           operand handshake
//   left, right                  dividend, divisor
//   out_valid, out_ready         result handshake
//   quotient, remainder          left / right, left % right
//   div_by_zero                  accepted right was zero
//
// state | meaning
// IDLE  | waiting for an operand pair
// BUSY  | iterating, one quotient bit per cycle
// HOLD  | result valid, waiting for the consumer
module std_divmod_stream
  import std_divmod_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             div_by_zero
);

  divmod_state_e    state_q, state_d;
  divmod_result_t   res_q;

  logic             accept, drain, step, last;
  logic [width-1:0] core_quotient, core_remainder;
  logic             core_div_by_zero;

  // A drain in HOLD frees the hold register on the same edge, so a new pair
  // can be taken then; this is the only path from out_ready to in_ready.
  assign in_ready  = reset_n && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        step = 1'b1;
        if (last) state_d = HOLD;
      end
      HOLD: if (drain) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  std_divmod_core #(.width(width)) u_core (
    .clk            (clk),
    .reset_n        (reset_n),
    .load           (accept),
    .step           (step),
    .left           (left),
    .right          (right),
    .last           (last),
    .quotient_next  (core_quotient),
    .remainder_next (core_remainder),
    .div_by_zero    (core_div_by_zero)
  );

  // Captures the final iteration's combinational result so the outputs only
  // move on the BUSY->HOLD edge and stay put through the next operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
    end else if ((state_q == BUSY) && last) begin
      res_q <= '{quotient:    MAX_WIDTH'(core_quotient),
                 remainder:   MAX_WIDTH'(core_remainder),
                 div_by_zero: core_div_by_zero};
    end
  end

  assign quotient    = res_q.quotient[width-1:0];
  assign remainder   = res_q.remainder[width-1:0];
  assign div_by_zero = res_q.div_by_zero;

  generate
    if (width < MAX_WIDTH) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^{res_q.quotient[MAX_WIDTH-1:width], res_q.remainder[MAX_WIDTH-1:width]};
    end
  endgenerate

endmodule

// File: tb/tb_std_divmod_stream.sv
module tb_std_divmod_stream;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_dbz;
  logic [31:0] a_left, a_right, a_quo, a_rem;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dbz;
  logic [7:0]  b_left, b_right, b_quo, b_rem;

  std_divmod_stream #(.width(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .left(a_left), .right(a_right), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .quotient(a_quo), .remainder(a_rem), .div_by_zero(a_dbz));

  std_divmod_stream #(.width(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .left(b_left), .right(b_right), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .quotient(b_quo), .remainder(b_rem), .div_by_zero(b_dbz));

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic exp_t golden(input logic [63:0] x, input logic [63:0] y, input int w);
    exp_t e;
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (y == 64'd0) begin
      e.q = mask; e.r = x; e.z = 1'b1;
    end else begin
      e.q = x / y; e.r = x % y; e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_left = 0; a_right = 0;
    b_in_valid = 0; b_out_ready = 0; b_left = 0; b_right = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    tests_run++; if (a_quo !== 32'd0) begin tests_failed++; $display("FAIL reset_quotient got %0h want 0", a_quo); end
    tests_run++; if (a_rem !== 32'd0) begin tests_failed++; $display("FAIL reset_remainder got %0h want 0", a_rem); end
    tests_run++; if (a_dbz !== 1'b0) begin tests_failed++; $display("FAIL reset_div_by_zero got %b want 0", a_dbz); end
    tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", a_in_ready); end
    tests_run++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_w8 got in_ready=%b out_valid=%b want 0 0", b_in_ready, b_out_valid); end
    reset_n = 1'b1;
    #1;
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready got %b want 1", a_in_ready); end
  endtask

  task automatic test_single_op(input logic [31:0] x, input logic [31:0] y, input string tag);
    exp_t e;
    int lat;
    bit seen;
    a_out_ready = 1'b1; a_left = x; a_right = y; a_in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_in_ready) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL %s_accept got in_ready=0 want 1", tag); end
    @(posedge clk);
    if (seen) sb_a.push_back(golden(64'(x), 64'(y), 32));
    #1;
    a_in_valid = 1'b0; a_left = $urandom; a_right = $urandom;
    lat = 0; seen = 0;
    for (int i = 1; i <= 96; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) begin lat = i; seen = 1; break; end
    end
    tests_run++; if (!seen || lat != 32) begin tests_failed++; $display("FAIL %s_latency got %0d want 32", tag, lat); end
    if (sb_a.size() == 0) begin
      tests_run++; tests_failed++; $display("FAIL %s_scoreboard got empty want entry", tag);
    end else begin
      e = sb_a.pop_front();
      tests_run++; if (a_quo !== e.q[31:0]) begin tests_failed++; $display("FAIL %s_quotient got %0h want %0h", tag, a_quo, e.q[31:0]); end
      tests_run++; if (a_rem !== e.r[31:0]) begin tests_failed++; $display("FAIL %s_remainder got %0h want %0h", tag, a_rem, e.r[31:0]); end
      tests_run++; if (a_dbz !== e.z) begin tests_failed++; $display("FAIL %s_div_by_zero got %b want %b", tag, a_dbz, e.z); end
      @(posedge clk); #1;
      tests_run++; if (a_out_valid !== 1'b0 || a_quo !== e.q[31:0]) begin tests_failed++; $display("FAIL %s_drain got out_valid=%b q=%0h want 0 %0h", tag, a_out_valid, a_quo, e.q[31:0]); end
    end
  endtask

  task automatic test_basic;
    test_single_op(32'd100, 32'd7, "basic");
  endtask

  task automatic test_div_by_zero;
    test_single_op(32'd5, 32'd0, "divzero");
  endtask

  task automatic test_extremes;
    test_single_op(32'hFFFF_FFFF, 32'd1, "max_by_1");
    test_single_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_by_max");
    test_single_op(32'd0, 32'd9, "zero_by_9");
    test_single_op(32'd3, 32'd10, "3_by_10");
  endtask

  task automatic test_backpressure;
    exp_t e;
    exp_t e2;
    int lat;
    bit seen;
    a_out_ready = 1'b0; a_left = 32'd1000; a_right = 32'd33; a_in_valid = 1'b1;
    #1;
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_idle_ready got %b want 1", a_in_ready); end
    @(posedge clk);
    sb_a.push_back(golden(64'd1000, 64'd33, 32));
    #1;
    a_in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 96; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) begin seen = 1; break; end
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL bp_out_valid got 0 want 1"); end
    e = sb_a.pop_front();
    a_left = 32'd77; a_right = 32'd5; a_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_hold got out_valid=%b in_ready=%b want 1 0", a_out_valid, a_in_ready); end
      tests_run++; if (a_quo !== e.q[31:0] || a_rem !== e.r[31:0]) begin tests_failed++; $display("FAIL bp_stable got q=%0h r=%0h want %0h %0h", a_quo, a_rem, e.q[31:0], e.r[31:0]); end
    end
    a_out_ready = 1'b1;
    #1;
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_drain_ready got %b want 1", a_in_ready); end
    @(posedge clk);
    sb_a.push_back(golden(64'd77, 64'd5, 32));
    #1;
    a_in_valid = 1'b0; a_left = $urandom; a_right = $urandom;
    tests_run++; if (a_out_valid !== 1'b0 || a_quo !== e.q[31:0]) begin tests_failed++; $display("FAIL bp_after_drain got out_valid=%b q=%0h want 0 %0h", a_out_valid, a_quo, e.q[31:0]); end
    lat = 0;
    for (int i = 1; i <= 96; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) begin lat = i; break; end
    end
    tests_run++; if (lat != 32) begin tests_failed++; $display("FAIL bp_second_latency got %0d want 32", lat); end
    e2 = sb_a.pop_front();
    tests_run++; if (a_quo !== e2.q[31:0] || a_rem !== e2.r[31:0]) begin tests_failed++; $display("FAIL bp_second_result got q=%0h r=%0h want %0h %0h", a_quo, a_rem, e2.q[31:0], e2.r[31:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    localparam int N = 1000;
    int sent_a, rcv_a, last_a, sent_b, rcv_b, last_b, cyc;
    bit acc_a, acc_b;
    exp_t e;
    sent_a = 0; rcv_a = 0; last_a = -1; sent_b = 0; rcv_b = 0; last_b = -1; cyc = 0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_left = $urandom; a_right = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom; a_in_valid = 1'b1;
    b_left = 8'($urandom_range(0, 255)); b_right = 8'($urandom_range(0, 255)); b_in_valid = 1'b1;
    while ((rcv_a < N || rcv_b < N) && cyc < 50000) begin
      @(negedge clk);
      acc_a = a_in_valid && a_in_ready;
      acc_b = b_in_valid && b_in_ready;
      if (a_out_valid && a_out_ready) begin
        if (sb_a.size() == 0) begin
          tests_run++; tests_failed++; $display("FAIL b2b32_scoreboard got empty want entry");
        end else begin
          e = sb_a.pop_front();
          tests_run++; if (a_quo !== e.q[31:0] || a_rem !== e.r[31:0] || a_dbz !== e.z) begin tests_failed++; $display("FAIL b2b32_result got q=%0h r=%0h z=%b want %0h %0h %b", a_quo, a_rem, a_dbz, e.q[31:0], e.r[31:0], e.z); end
        end
        if (last_a >= 0) begin
          tests_run++; if (cyc - last_a != 33) begin tests_failed++; $display("FAIL b2b32_spacing got %0d want 33", cyc - last_a); end
        end
        last_a = cyc; rcv_a++;
      end
      if (b_out_valid && b_out_ready) begin
        if (sb_b.size() == 0) begin
          tests_run++; tests_failed++; $display("FAIL b2b8_scoreboard got empty want entry");
        end else begin
          e = sb_b.pop_front();
          tests_run++; if (b_quo !== e.q[7:0] || b_rem !== e.r[7:0] || b_dbz !== e.z) begin tests_failed++; $display("FAIL b2b8_result got q=%0h r=%0h z=%b want %0h %0h %b", b_quo, b_rem, b_dbz, e.q[7:0], e.r[7:0], e.z); end
        end
        if (last_b >= 0) begin
          tests_run++; if (cyc - last_b != 9) begin tests_failed++; $display("FAIL b2b8_spacing got %0d want 9", cyc - last_b); end
        end
        last_b = cyc; rcv_b++;
      end
      @(posedge clk);
      if (acc_a) begin sb_a.push_back(golden(64'(a_left), 64'(a_right), 32)); sent_a++; end
      if (acc_b) begin sb_b.push_back(golden(64'(b_left), 64'(b_right), 8)); sent_b++; end
      #1;
      if (acc_a) begin
        if (sent_a < N) begin
          a_left = $urandom; a_right = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
        end else a_in_valid = 1'b0;
      end
      if (acc_b) begin
        if (sent_b < N) begin
          b_left = 8'($urandom_range(0, 255)); b_right = 8'($urandom_range(0, 255));
        end else b_in_valid = 1'b0;
      end
      cyc++;
    end
    tests_run++; if (rcv_a != N || rcv_b != N) begin tests_failed++; $display("FAIL b2b_count got %0d/%0d want %0d/%0d", rcv_a, rcv_b, N, N); end
  endtask

  task automatic test_reset_mid;
    bit rose;
    a_out_ready = 1'b1; a_left = 32'd500; a_right = 32'd7; a_in_valid = 1'b1;
    #1;
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_accept got in_ready=%b want 1", a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    tests_run++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_handshake got out_valid=%b in_ready=%b want 0 0", a_out_valid, a_in_ready); end
    tests_run++; if (a_quo !== 32'd0 || a_rem !== 32'd0 || a_dbz !== 1'b0) begin tests_failed++; $display("FAIL rstmid_outputs got q=%0h r=%0h z=%b want 0 0 0", a_quo, a_rem, a_dbz); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) rose = 1;
    end
    tests_run++; if (rose) begin tests_failed++; $display("FAIL rstmid_no_result got out_valid=1 want 0"); end
    test_single_op(32'd1234567, 32'd89, "post_reset");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div_by_zero;
    test_extremes;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
